// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and constants for the voice envelope path
package synth_pkg;

    localparam int         SAMPLE_W = 8;
    localparam logic [8:0] GAIN_MAX = 9'd256;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        HOLD    = 3'd2,
        DECAY   = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    // Gain arithmetic runs 10 bits wide; this folds a result back into 0..256.
    function automatic logic [8:0] clamp_gain(input logic [9:0] g);
        if (g > {1'b0, GAIN_MAX}) begin
            return GAIN_MAX;
        end
        return g[8:0];
    endfunction

endpackage

// File: rtl/env_tick.sv
// rtl/env_tick.sv - free-running divider producing a one-cycle envelope tick
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   tick    - high for one clk when the counter sits at TICK_DIV-1
module env_tick #(
    parameter int TICK_DIV = 625000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int                CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/note_envelope.sv
// rtl/note_envelope.sv - per-voice attack/hold/decay/release gain and sample scaling
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   key_on     - voice-active level, asynchronous to clk
//   sample_in  - unsigned voice sample
//   sample_out - sample_in scaled by gain, registered
//   gain       - current gain, 0..256 (256 = unity)
//   env_state  - current envelope state
//   active     - envelope is not IDLE
module note_envelope
    import synth_pkg::*;
#(
    parameter int TICK_DIV     = 625000,
    parameter int ATTACK_STEP  = 16,
    parameter int HOLD_TICKS   = 31,
    parameter int DECAY_STEP   = 2,
    parameter int RELEASE_STEP = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                key_on,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic [8:0]          gain,
    output env_state_t          env_state,
    output logic                active
);

    localparam int HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

    logic              key_s1, key_s2, key_s3;
    logic              key_rise, key_fall;
    logic              tick;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
    logic [8:0]        gain_d;
    env_state_t        state_d;
    logic [9:0]        gain_w;
    logic [16:0]       product;

    env_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Two flops to resolve metastability, a third to find the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
            key_s3 <= 1'b0;
        end else begin
            key_s1 <= key_on;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
        end
    end

    assign key_rise = key_s2 & ~key_s3;
    assign key_fall = ~key_s2 & key_s3;
    assign gain_w   = {1'b0, gain};
    assign active   = (env_state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            env_state <= IDLE;
            gain      <= '0;
            hold_cnt  <= '0;
        end else begin
            env_state <= state_d;
            gain      <= gain_d;
            hold_cnt  <= hold_cnt_d;
        end
    end

    // Key events win over tick; a retrigger keeps the present gain so the
    // attack ramp starts where the previous envelope left off.
    always_comb begin
        state_d    = env_state;
        gain_d     = gain;
        hold_cnt_d = hold_cnt;
        case (env_state)
            IDLE: begin
                if (key_rise) state_d = ATTACK;
            end
            ATTACK: begin
                if (key_fall) begin
                    state_d = RELEASE;
                end else if (tick && !key_rise) begin
                    gain_d = clamp_gain(gain_w + 10'(ATTACK_STEP));
                    if (gain_d == GAIN_MAX) begin
                        state_d    = HOLD;
                        hold_cnt_d = HOLD_W'(HOLD_TICKS);
                    end
                end
            end
            HOLD: begin
                if (key_fall) begin
                    state_d = RELEASE;
                end else if (tick && !key_rise) begin
                    if (hold_cnt == '0) state_d = DECAY;
                    else                hold_cnt_d = hold_cnt - 1'b1;
                end
            end
            DECAY: begin
                if (key_fall) begin
                    state_d = RELEASE;
                end else if (key_rise) begin
                    state_d = ATTACK;
                end else if (tick) begin
                    gain_d = (gain_w <= 10'(DECAY_STEP)) ? 9'd0
                           : clamp_gain(gain_w - 10'(DECAY_STEP));
                    if (gain_d == 9'd0) state_d = IDLE;
                end
            end
            RELEASE: begin
                if (key_rise) begin
                    state_d = ATTACK;
                end else if (tick && !key_fall) begin
                    gain_d = (gain_w <= 10'(RELEASE_STEP)) ? 9'd0
                           : clamp_gain(gain_w - 10'(RELEASE_STEP));
                    if (gain_d == 9'd0) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gain_d  = '0;
            end
        endcase
    end

    // Unity gain is 256, so the scaled sample is the product shifted by 8.
    assign product = 17'(sample_in) * 17'(gain);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_out <= '0;
        end else begin
            sample_out <= 8'(product >> 8);
        end
    end

endmodule

// File: tb/tb_note_envelope.sv
// tb/tb_note_envelope.sv - directed self-checking bench for note_envelope
module tb_note_envelope;
    import synth_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_on = 1'b0;
    logic [7:0] sample_in = 8'd200;
    logic [7:0] sample_out;
    logic [8:0] gain;
    env_state_t env_state;
    logic       active;

    int tests = 0;
    int fails = 0;
    int hold_cycles;
    int max_step;
    logic [7:0] prev_so;

    note_envelope #(
        .TICK_DIV     (4),
        .ATTACK_STEP  (64),
        .HOLD_TICKS   (2),
        .DECAY_STEP   (16),
        .RELEASE_STEP (64)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_on     (key_on),
        .sample_in  (sample_in),
        .sample_out (sample_out),
        .gain       (gain),
        .env_state  (env_state),
        .active     (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        int d;
        @(negedge clk);
        d = int'(sample_out) - int'(prev_so);
        if (d < 0) d = -d;
        if (d > max_step) max_step = d;
        prev_so = sample_out;
    endtask

    task automatic wait_gain(input string tag, input logic [8:0] exp);
        logic [8:0] start;
        start = gain;
        for (int i = 0; i < 40; i++) begin
            step_clk();
            if (gain !== start) break;
        end
        check(tag, 32'(gain), 32'(exp));
    endtask

    task automatic wait_state(input string tag, input env_state_t st);
        for (int i = 0; i < 100; i++) begin
            if (env_state == st) break;
            step_clk();
        end
        check(tag, 32'(env_state), 32'(st));
    endtask

    initial begin
        prev_so  = 8'd0;
        max_step = 0;

        // Reset held with key toggling: nothing moves
        for (int i = 0; i < 6; i++) begin
            key_on = ~key_on;
            step_clk();
            check("rst_state", 32'(env_state), 32'(IDLE));
            check("rst_gain", 32'(gain), 32'd0);
            check("rst_sout", 32'(sample_out), 32'd0);
        end
        key_on = 1'b0;
        step_clk();
        reset_n = 1'b1;
        repeat (3) step_clk();
        check("idle_active", 32'(active), 32'd0);

        // Attack: key edge reaches the FSM on the third clk
        key_on = 1'b1;
        step_clk();
        step_clk();
        check("rise_lat_idle", 32'(env_state), 32'(IDLE));
        step_clk();
        check("rise_attack", 32'(env_state), 32'(ATTACK));
        check("attack_active", 32'(active), 32'd1);
        wait_gain("att_64", 9'd64);
        wait_gain("att_128", 9'd128);
        wait_gain("att_192", 9'd192);
        wait_gain("att_256", 9'd256);
        check("hold_entry", 32'(env_state), 32'(HOLD));
        check("sout_pre", 32'(sample_out), 32'd150);
        step_clk();
        check("sout_unity", 32'(sample_out), 32'd200);

        // HOLD lasts three ticks = 12 clk
        hold_cycles = 2;
        for (int i = 0; i < 30; i++) begin
            step_clk();
            if (env_state != HOLD) break;
            hold_cycles++;
        end
        check("hold_len", 32'(hold_cycles), 32'd12);
        check("decay_entry", 32'(env_state), 32'(DECAY));
        check("decay_gain0", 32'(gain), 32'd256);

        // Decay to zero in 16 steps
        for (int k = 1; k <= 16; k++) begin
            wait_gain("decay_step", 9'(256 - 16 * k));
        end
        check("decay_idle", 32'(env_state), 32'(IDLE));
        check("decay_inactive", 32'(active), 32'd0);

        // Release from HOLD
        key_on = 1'b0;
        repeat (3) step_clk();
        key_on = 1'b1;
        wait_state("rel_hold", HOLD);
        key_on = 1'b0;
        step_clk();
        step_clk();
        check("fall_lat_hold", 32'(env_state), 32'(HOLD));
        step_clk();
        check("fall_release", 32'(env_state), 32'(RELEASE));
        check("fall_gain", 32'(gain), 32'd256);
        wait_gain("rel_192", 9'd192);
        wait_gain("rel_128", 9'd128);
        wait_gain("rel_64", 9'd64);
        wait_gain("rel_0", 9'd0);
        check("rel_idle", 32'(env_state), 32'(IDLE));

        // Retrigger during release at gain 128
        key_on = 1'b1;
        wait_state("rt_hold", HOLD);
        key_on = 1'b0;
        wait_state("rt_release", RELEASE);
        wait_gain("rt_192", 9'd192);
        wait_gain("rt_128", 9'd128);
        key_on = 1'b1;
        max_step = 0;
        repeat (3) step_clk();
        check("rt_attack", 32'(env_state), 32'(ATTACK));
        check("rt_gain_kept", 32'(gain), 32'd128);
        wait_gain("rt_att_192", 9'd192);
        wait_gain("rt_att_256", 9'd256);
        check("rt_hold2", 32'(env_state), 32'(HOLD));
        step_clk();
        check("rt_max_step", 32'(max_step), 32'd50);

        // Asynchronous reset mid-ATTACK at gain 128
        key_on = 1'b0;
        wait_state("ar_idle", IDLE);
        key_on = 1'b1;
        wait_gain("ar_64", 9'd64);
        wait_gain("ar_128", 9'd128);
        check("ar_attack", 32'(env_state), 32'(ATTACK));
        step_clk();
        check("ar_sout_half", 32'(sample_out), 32'd100);
        #2 reset_n = 1'b0;
        #1;
        check("ar_gain", 32'(gain), 32'd0);
        check("ar_sout", 32'(sample_out), 32'd0);
        check("ar_state", 32'(env_state), 32'(IDLE));
        check("ar_active", 32'(active), 32'd0);
        key_on = 1'b0;
        repeat (3) step_clk();
        reset_n = 1'b1;
        repeat (8) step_clk();
        check("post_rst_state", 32'(env_state), 32'(IDLE));
        check("post_rst_gain", 32'(gain), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
